// File: rtl/ct_ifu_spsram_512x44_ctrl.sv
// ----------------------------------------------------------------------------
// ct_ifu_spsram_512x44_ctrl
//
// Access controller for one single-port IFU SRAM macro (512 x 44 by default,
// active-low CEN / GWEN / per-bit WEN). The one SRAM port is shared by three
// requesters in fixed priority: an invalidate sweeper, a refill/update write
// port, and a lookup read port. A starvation counter lets a blocked read win
// over a write once it has waited STARVE_LIMIT cycles.
//
// Ports:
//   forever_cpuclk            clock
//   cpurst                    asynchronous active-high reset
//   inv_req / inv_busy        start/restart invalidate sweep; sweep pending/active
//   wr_req/wr_addr/wr_data/wr_mask/wr_gnt
//                             write request (mask 1 = write bit), same-cycle grant
//   rd_req/rd_addr/rd_gnt     read request, same-cycle grant
//   rd_vld/rd_data            read return, one cycle after rd_gnt
//   sram_a/sram_cen/sram_gwen/sram_d/sram_wen/sram_q
//                             SRAM macro interface (controls active low)
// ----------------------------------------------------------------------------
module ct_ifu_spsram_512x44_ctrl #(
    parameter int ADDR_WIDTH    = 9,
    parameter int DATA_WIDTH    = 44,
    parameter int INIT_ON_RESET = 1,
    parameter int STARVE_LIMIT  = 4
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst,
    input  logic                  inv_req,
    output logic                  inv_busy,
    input  logic                  wr_req,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [DATA_WIDTH-1:0] wr_mask,
    output logic                  wr_gnt,
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_gnt,
    output logic                  rd_vld,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic                  sram_cen,
    output logic                  sram_gwen,
    output logic [DATA_WIDTH-1:0] sram_d,
    output logic [DATA_WIDTH-1:0] sram_wen,
    input  logic [DATA_WIDTH-1:0] sram_q
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_INV  = 1'b1;

    localparam logic [ADDR_WIDTH-1:0] CNT_LAST   = {ADDR_WIDTH{1'b1}};
    localparam logic [SW-1:0]         STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic                  PEND_RST   = (INIT_ON_RESET != 0);

    logic [0:0]            state;
    logic                  start_pend;
    logic [ADDR_WIDTH-1:0] cnt;
    logic [SW-1:0]         starve_cnt;
    logic                  rd_vld_q;

    logic                  go_inv;
    logic                  wr_win;
    logic                  rd_win;

    // IDLE -> INV transition is taken this cycle; it suppresses any grant
    assign go_inv = (state == ST_IDLE) & (start_pend | inv_req);

    assign inv_busy = (state == ST_INV) | start_pend;
    assign wr_gnt   = wr_win;
    assign rd_gnt   = rd_win;
    assign rd_vld   = rd_vld_q;
    assign rd_data  = sram_q;

    // Same-cycle arbitration between write and read while idle
    always_comb begin
        wr_win = 1'b0;
        rd_win = 1'b0;
        if (cpurst || (state != ST_IDLE) || go_inv) begin
            wr_win = 1'b0;
            rd_win = 1'b0;
        end else if (wr_req && rd_req) begin
            // A read that has lost STARVE_LIMIT times in a row takes the port
            if (starve_cnt == STARVE_MAX) begin
                rd_win = 1'b1;
            end else begin
                wr_win = 1'b1;
            end
        end else begin
            wr_win = wr_req;
            rd_win = rd_req;
        end
    end

    // SRAM port drive: sweep, granted write, granted read, or quiet
    always_comb begin
        sram_cen  = 1'b1;
        sram_gwen = 1'b1;
        sram_wen  = {DATA_WIDTH{1'b1}};
        sram_a    = {ADDR_WIDTH{1'b0}};
        sram_d    = {DATA_WIDTH{1'b0}};
        if (cpurst) begin
            sram_cen = 1'b1;
        end else if (state == ST_INV) begin
            sram_cen  = 1'b0;
            sram_gwen = 1'b0;
            sram_wen  = {DATA_WIDTH{1'b0}};
            sram_a    = cnt;
        end else if (wr_win) begin
            sram_cen  = 1'b0;
            sram_gwen = 1'b0;
            sram_wen  = ~wr_mask;
            sram_a    = wr_addr;
            sram_d    = wr_data;
        end else if (rd_win) begin
            sram_cen = 1'b0;
            sram_a   = rd_addr;
        end else begin
            sram_cen = 1'b1;
        end
    end

    // Sweep FSM, counters and read-valid pipeline
    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            state      <= ST_IDLE;
            start_pend <= PEND_RST;
            cnt        <= {ADDR_WIDTH{1'b0}};
            starve_cnt <= {SW{1'b0}};
            rd_vld_q   <= 1'b0;
        end else begin
            rd_vld_q <= rd_win;
            case (state)
                ST_IDLE: begin
                    if (go_inv) begin
                        state      <= ST_INV;
                        cnt        <= {ADDR_WIDTH{1'b0}};
                        start_pend <= 1'b0;
                    end else begin
                        state <= ST_IDLE;
                    end
                    if (rd_req && !rd_win) begin
                        if (starve_cnt != STARVE_MAX) begin
                            starve_cnt <= starve_cnt + SW'(1);
                        end else begin
                            starve_cnt <= starve_cnt;
                        end
                    end else begin
                        starve_cnt <= {SW{1'b0}};
                    end
                end
                ST_INV: begin
                    // A new request restarts the sweep from address 0
                    if (inv_req) begin
                        cnt <= {ADDR_WIDTH{1'b0}};
                    end else if (cnt == CNT_LAST) begin
                        cnt   <= {ADDR_WIDTH{1'b0}};
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + ADDR_WIDTH'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ct_ifu_spsram_512x44_ctrl.sv
// ----------------------------------------------------------------------------
// Self-checking bench for ct_ifu_spsram_512x44_ctrl. A behavioural SRAM model
// sits on the macro side; a reference array tracks what the SRAM should hold
// and expected read data is queued at grant time, then checked on rd_vld.
// ----------------------------------------------------------------------------
module tb_ct_ifu_spsram_512x44_ctrl;

    localparam int AW = 9;
    localparam int DW = 44;

    logic          clk = 1'b0;
    logic          rst;
    logic          inv_req;
    logic          inv_busy;
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] wr_mask;
    logic          wr_gnt;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_gnt;
    logic          rd_vld;
    logic [DW-1:0] rd_data;
    logic [AW-1:0] sram_a;
    logic          sram_cen;
    logic          sram_gwen;
    logic [DW-1:0] sram_d;
    logic [DW-1:0] sram_wen;
    logic [DW-1:0] sram_q;

    int vectors     = 0;
    int miscompares = 0;

    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic          fill;

    always #5 clk = ~clk;

    ct_ifu_spsram_512x44_ctrl dut (
        .forever_cpuclk(clk),
        .cpurst        (rst),
        .inv_req       (inv_req),
        .inv_busy      (inv_busy),
        .wr_req        (wr_req),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_mask       (wr_mask),
        .wr_gnt        (wr_gnt),
        .rd_req        (rd_req),
        .rd_addr       (rd_addr),
        .rd_gnt        (rd_gnt),
        .rd_vld        (rd_vld),
        .rd_data       (rd_data),
        .sram_a        (sram_a),
        .sram_cen      (sram_cen),
        .sram_gwen     (sram_gwen),
        .sram_d        (sram_d),
        .sram_wen      (sram_wen),
        .sram_q        (sram_q)
    );

    // SRAM macro model: write-then-read ordered, registered read data
    always @(posedge clk) begin
        if (fill) begin
            for (int i = 0; i < (1<<AW); i++) begin
                mem[i] <= DW'(i * 32'h9E3779B1) ^ 44'h5A5_A5A5_A5A5;
            end
        end else if (!sram_cen) begin
            if (!sram_gwen) begin
                mem[sram_a] <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
            end else begin
                sram_q <= mem[sram_a];
            end
        end
    end

    // Read-return scoreboard
    always @(negedge clk) begin
        logic [DW-1:0] e;
        if (rd_vld === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL rd_vld_unexpected: rd_vld=1 with no read outstanding");
            end else begin
                e = exp_q.pop_front();
                if (rd_data !== e) begin
                    miscompares++;
                    $display("FAIL rd_data: got %h expected %h", rd_data, e);
                end
            end
        end
    end

    task automatic idle_inputs();
        inv_req = 1'b0;
        wr_req  = 1'b0;
        rd_req  = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        wr_mask = '0;
        rd_addr = '0;
    endtask

    // Expects the next negedge to be sweep address 0; runs the full sweep
    task automatic test_sweep_run(input string tag);
        for (int i = 0; i < (1<<AW); i++) begin
            @(negedge clk);
            inv_req = 1'b0;
            #1;
            vectors++;
            if (sram_a !== AW'(i) || sram_cen !== 1'b0 || sram_gwen !== 1'b0 ||
                sram_wen !== {DW{1'b0}} || sram_d !== {DW{1'b0}} ||
                inv_busy !== 1'b1 || wr_gnt !== 1'b0 || rd_gnt !== 1'b0) begin
                miscompares++;
                $display("FAIL %s_sweep[%0d]: a=%h cen=%b gwen=%b wen=%h d=%h busy=%b wg=%b rg=%b expected a=%h cen=0 gwen=0 wen=0 d=0 busy=1 no grants",
                         tag, i, sram_a, sram_cen, sram_gwen, sram_wen, sram_d, inv_busy, wr_gnt, rd_gnt, AW'(i));
            end
        end
        @(negedge clk);
        idle_inputs();
        #1;
        vectors++;
        if (inv_busy !== 1'b0 || sram_cen !== 1'b1) begin
            miscompares++;
            $display("FAIL %s_done: inv_busy=%b cen=%b expected 0 and 1", tag, inv_busy, sram_cen);
        end
        for (int i = 0; i < (1<<AW); i++) ref_mem[i] = '0;
    endtask

    task automatic drain();
        for (int n = 0; n < 4 && exp_q.size() != 0; n++) begin
            @(negedge clk);
            #1;
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d reads never returned, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst  = 1'b1;
        fill = 1'b1;
        @(posedge clk);
        #1;
        fill    = 1'b0;
        wr_req  = 1'b1;
        rd_req  = 1'b1;
        wr_mask = '1;
        #1;
        vectors++;
        if (sram_cen !== 1'b1 || sram_gwen !== 1'b1 || sram_wen !== {DW{1'b1}} ||
            sram_a !== '0 || sram_d !== '0) begin
            miscompares++;
            $display("FAIL reset_sram: cen=%b gwen=%b wen=%h a=%h d=%h expected 1 1 all-ones 0 0",
                     sram_cen, sram_gwen, sram_wen, sram_a, sram_d);
        end
        vectors++;
        if (wr_gnt !== 1'b0 || rd_gnt !== 1'b0 || rd_vld !== 1'b0 || inv_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ctl: wg=%b rg=%b vld=%b busy=%b expected 0 0 0 1",
                     wr_gnt, rd_gnt, rd_vld, inv_busy);
        end
        @(negedge clk);
        rst    = 1'b0;
        rd_req = 1'b0;
        #1;
        vectors++;
        if (inv_busy !== 1'b1 || sram_cen !== 1'b1 || wr_gnt !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_pend: busy=%b cen=%b wg=%b expected 1 1 0", inv_busy, sram_cen, wr_gnt);
        end
        test_sweep_run("init");
    endtask

    task automatic test_write_read();
        @(negedge clk);
        wr_req  = 1'b1;
        wr_addr = 9'h1A5;
        wr_data = 44'hABC_DEF0_1234;
        wr_mask = '1;
        #1;
        vectors++;
        if (wr_gnt !== 1'b1 || rd_gnt !== 1'b0 || sram_cen !== 1'b0 || sram_gwen !== 1'b0 ||
            sram_wen !== {DW{1'b0}} || sram_a !== 9'h1A5 || sram_d !== 44'hABC_DEF0_1234) begin
            miscompares++;
            $display("FAIL wr_full: wg=%b rg=%b cen=%b gwen=%b wen=%h a=%h d=%h expected 1 0 0 0 0 1a5 abcdef01234",
                     wr_gnt, rd_gnt, sram_cen, sram_gwen, sram_wen, sram_a, sram_d);
        end
        ref_mem[9'h1A5] = 44'hABC_DEF0_1234;
        @(negedge clk);
        idle_inputs();
        rd_req  = 1'b1;
        rd_addr = 9'h1A5;
        #1;
        vectors++;
        if (rd_gnt !== 1'b1 || sram_cen !== 1'b0 || sram_gwen !== 1'b1 ||
            sram_wen !== {DW{1'b1}} || sram_a !== 9'h1A5) begin
            miscompares++;
            $display("FAIL rd_grant: rg=%b cen=%b gwen=%b wen=%h a=%h expected 1 0 1 all-ones 1a5",
                     rd_gnt, sram_cen, sram_gwen, sram_wen, sram_a);
        end
        exp_q.push_back(ref_mem[9'h1A5]);
        @(negedge clk);
        idle_inputs();
        #1;
        vectors++;
        if (rd_vld !== 1'b1) begin
            miscompares++;
            $display("FAIL rd_vld_latency: rd_vld=%b expected 1", rd_vld);
        end
        drain();
    endtask

    task automatic test_partial_mask();
        @(negedge clk);
        wr_req  = 1'b1;
        wr_addr = 9'h1A5;
        wr_data = 44'h123_4567_89AB;
        wr_mask = 44'h000_0000_FFFF;
        #1;
        vectors++;
        if (wr_gnt !== 1'b1 || sram_wen !== 44'hFFF_FFFF_0000) begin
            miscompares++;
            $display("FAIL wr_partial: wg=%b wen=%h expected 1 fffffff0000", wr_gnt, sram_wen);
        end
        ref_mem[9'h1A5] = (ref_mem[9'h1A5] & ~wr_mask) | (wr_data & wr_mask);
        @(negedge clk);
        wr_data = '1;
        wr_mask = '0;
        #1;
        vectors++;
        if (wr_gnt !== 1'b1 || sram_cen !== 1'b0 || sram_gwen !== 1'b0 || sram_wen !== {DW{1'b1}}) begin
            miscompares++;
            $display("FAIL wr_zero_mask: wg=%b cen=%b gwen=%b wen=%h expected 1 0 0 all-ones",
                     wr_gnt, sram_cen, sram_gwen, sram_wen);
        end
        @(negedge clk);
        idle_inputs();
        rd_req  = 1'b1;
        rd_addr = 9'h1A5;
        #1;
        vectors++;
        if (rd_gnt !== 1'b1) begin
            miscompares++;
            $display("FAIL partial_rd_grant: rg=%b expected 1", rd_gnt);
        end
        exp_q.push_back(ref_mem[9'h1A5]);
        @(negedge clk);
        idle_inputs();
        drain();
    endtask

    task automatic test_starvation();
        logic exp_rd;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            wr_req  = 1'b1;
            rd_req  = 1'b1;
            wr_addr = AW'(9'h100 + k);
            wr_data = {12'($urandom), $urandom};
            wr_mask = '1;
            rd_addr = 9'h100;
            #1;
            exp_rd = ((k % 5) == 4);
            vectors++;
            if (wr_gnt !== !exp_rd || rd_gnt !== exp_rd) begin
                miscompares++;
                $display("FAIL starve[%0d]: wg=%b rg=%b expected %b %b", k, wr_gnt, rd_gnt, !exp_rd, exp_rd);
            end
            if (exp_rd) exp_q.push_back(ref_mem[9'h100]);
            else ref_mem[wr_addr] = wr_data;
        end
        @(negedge clk);
        idle_inputs();
        drain();
    endtask

    task automatic test_inv_restart();
        @(negedge clk);
        inv_req = 1'b1;
        wr_req  = 1'b1;
        wr_addr = 9'h1A5;
        wr_mask = '1;
        #1;
        vectors++;
        if (wr_gnt !== 1'b0 || sram_cen !== 1'b1) begin
            miscompares++;
            $display("FAIL inv_start: wg=%b cen=%b expected 0 1", wr_gnt, sram_cen);
        end
        for (int i = 0; i <= 300; i++) begin
            @(negedge clk);
            inv_req = (i == 300);
            #1;
            vectors++;
            if (sram_a !== AW'(i) || sram_cen !== 1'b0 || inv_busy !== 1'b1 || wr_gnt !== 1'b0) begin
                miscompares++;
                $display("FAIL pre_restart[%0d]: a=%h cen=%b busy=%b wg=%b expected %h 0 1 0",
                         i, sram_a, sram_cen, inv_busy, wr_gnt, AW'(i));
            end
        end
        test_sweep_run("restart");
        // Back-to-back reads of swept locations
        @(negedge clk);
        rd_req  = 1'b1;
        rd_addr = 9'h1A5;
        #1;
        vectors++;
        if (rd_gnt !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_rd0: rg=%b expected 1", rd_gnt);
        end
        exp_q.push_back(ref_mem[9'h1A5]);
        @(negedge clk);
        rd_addr = 9'h100;
        #1;
        vectors++;
        if (rd_gnt !== 1'b1 || rd_vld !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_rd1: rg=%b vld=%b expected 1 1", rd_gnt, rd_vld);
        end
        exp_q.push_back(ref_mem[9'h100]);
        @(negedge clk);
        idle_inputs();
        drain();
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        inv_req = 1'b1;
        for (int i = 0; i <= 100; i++) begin
            @(negedge clk);
            inv_req = 1'b0;
            #1;
            vectors++;
            if (sram_a !== AW'(i) || sram_cen !== 1'b0) begin
                miscompares++;
                $display("FAIL mid_sweep[%0d]: a=%h cen=%b expected %h 0", i, sram_a, sram_cen, AW'(i));
            end
        end
        rst = 1'b1;
        #1;
        vectors++;
        if (sram_cen !== 1'b1 || sram_gwen !== 1'b1 || sram_wen !== {DW{1'b1}} ||
            sram_a !== '0 || inv_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_reset: cen=%b gwen=%b wen=%h a=%h busy=%b expected 1 1 all-ones 0 1",
                     sram_cen, sram_gwen, sram_wen, sram_a, inv_busy);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        vectors++;
        if (inv_busy !== 1'b1 || sram_cen !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_pend: busy=%b cen=%b expected 1 1", inv_busy, sram_cen);
        end
        test_sweep_run("post_reset");
        // A read granted just before reset must never return
        @(negedge clk);
        rd_req  = 1'b1;
        rd_addr = 9'h005;
        #1;
        vectors++;
        if (rd_gnt !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_rst_rd: rg=%b expected 1", rd_gnt);
        end
        #1;
        rst = 1'b1;
        #1;
        vectors++;
        if (rd_gnt !== 1'b0 || sram_cen !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_gate: rg=%b cen=%b expected 0 1", rd_gnt, sram_cen);
        end
        @(negedge clk);
        rd_req = 1'b0;
        #1;
        vectors++;
        if (rd_vld !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_rd_vld: rd_vld=%b expected 0", rd_vld);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        vectors++;
        if (inv_busy !== 1'b1 || rd_vld !== 1'b0) begin
            miscompares++;
            $display("FAIL rst2_pend: busy=%b vld=%b expected 1 0", inv_busy, rd_vld);
        end
        test_sweep_run("post_reset2");
        drain();
    endtask

    initial begin
        fill   = 1'b0;
        sram_q = '0;
        for (int i = 0; i < (1<<AW); i++) ref_mem[i] = '0;
        test_reset();
        test_write_read();
        test_partial_mask();
        test_starvation();
        test_inv_restart();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ct_ifu_spsram_512x44_ctrl.md
Name: ct_ifu_spsram_512x44_ctrl

Overview:
- Access controller for one 512-entry x 44-bit single-port IFU SRAM macro (active-low CEN/GWEN/per-bit WEN).
- Shares the single port between three requesters:
  - a whole-array invalidate sweeper, run automatically after reset and on request;
  - a refill/update write port;
  - a lookup read port.
- Sits between the IFU pipeline/refill logic and the SRAM instance.
- Fixed priority: sweep > write > read, with an anti-starvation override for reads.

Parameters:
- ADDR_WIDTH, 9: SRAM address width (depth 2^ADDR_WIDTH).
- DATA_WIDTH, 44: SRAM data width.
- INIT_ON_RESET, 1: 1 = start an invalidate sweep on the first cycle after reset release.
- STARVE_LIMIT, 4: consecutive write-blocked read cycles after which the read wins over a write.

Ports:
- forever_cpuclk  in  1  clock
- cpurst  in  1  asynchronous active-high reset
- inv_req  in  1  pulse: start/restart invalidate sweep
- inv_busy  out  1  sweep pending or in progress
- wr_req  in  1  write request
- wr_addr  in  ADDR_WIDTH  write address
- wr_data  in  DATA_WIDTH  write data
- wr_mask  in  DATA_WIDTH  per-bit write enable, 1 = write
- wr_gnt  out  1  write accepted this cycle
- rd_req  in  1  read request
- rd_addr  in  ADDR_WIDTH  read address
- rd_gnt  out  1  read accepted this cycle
- rd_vld  out  1  read data valid (one cycle after rd_gnt)
- rd_data  out  DATA_WIDTH  read data
- sram_a  out  ADDR_WIDTH  SRAM address
- sram_cen  out  1  SRAM chip enable, active low
- sram_gwen  out  1  SRAM global write enable, active low
- sram_d  out  DATA_WIDTH  SRAM write data
- sram_wen  out  DATA_WIDTH  SRAM bit write enable, active low
- sram_q  in  DATA_WIDTH  SRAM read data

Behaviour:
- Clock and reset: one clock, forever_cpuclk. Reset cpurst is asynchronous and active-high.
- Registered state:
  - FSM state: IDLE or INV.
  - start_pend flag.
  - sweep counter, ADDR_WIDTH bits.
  - starve_cnt, wide enough to hold STARVE_LIMIT.
  - rd_vld_q.
- Reset values:
  - state = IDLE, counter = 0, starve_cnt = 0, rd_vld = 0.
  - start_pend = INIT_ON_RESET.
  - With reset asserted: sram_cen = 1, sram_gwen = 1, sram_wen = all 1, sram_a = 0, sram_d = 0, wr_gnt = rd_gnt = 0.
  - inv_busy = INIT_ON_RESET while in reset.
- IDLE state:
  - start_pend = 1 or inv_req = 1 -> next state INV, counter = 0, start_pend cleared.
  - Otherwise arbitrate between write and read.
- INV state: every cycle drives cen = 0, gwen = 0, wen = all 0, d = 0, a = counter.
  - Counter increments each cycle.
  - At counter = 2^ADDR_WIDTH-1: the write is performed, counter wraps to 0, next state IDLE.
  - Sweep length is exactly 512 cycles at default parameters.
  - inv_req during INV: counter resets to 0 next cycle and the sweep restarts in full.
  - wr_gnt = rd_gnt = 0 throughout INV. starve_cnt holds its value.
- inv_busy = (state == INV) | start_pend. It is combinational on registered state.
- Arbitration in IDLE, combinational and same cycle:
  - If the INV transition is being taken this cycle, there are no grants and cen = 1.
  - Otherwise, when wr_req and rd_req are both high, the write wins unless starve_cnt == STARVE_LIMIT, in which case the read wins.
  - When only one request is high, it is granted.
  - When neither is high, cen = 1, gwen = 1, wen = all 1.
- Write grant: cen = 0, gwen = 0, a = wr_addr, d = wr_data, wen = ~wr_mask.
  - wr_mask = 0 still issues the access; it writes no bits.
- Read grant: cen = 0, gwen = 1, wen = all 1, a = rd_addr. sram_d is don't-care, driven 0.
- Read return: rd_vld_q <= rd_gnt, so rd_vld rises exactly 1 cycle after rd_gnt. rd_data = sram_q, passed straight through.
  - rd_data is meaningful only while rd_vld = 1.
  - A back-to-back read grant produces rd_vld on consecutive cycles.
- starve_cnt:
  - Increments, saturating at STARVE_LIMIT, on each IDLE cycle with rd_req = 1 and rd_gnt = 0.
  - Clears on rd_gnt or rd_req = 0.
- Ordering: a read granted in the cycle after a write to the same address returns the new data. The SRAM is write-then-read ordered; the controller adds no bypass.
- Reset mid-sweep: all state returns to reset values. With INIT_ON_RESET = 1 the sweep restarts from address 0 after release.

Test Plan:
1. Reset release with INIT_ON_RESET = 1:
   - inv_busy = 1 for 513 cycles (1 pend + 512 sweep).
   - sram_a counts 0..511 with cen = 0, gwen = 0, wen = 0, d = 0.
   - No grants during this window. After the sweep, inv_busy = 0.
2. Write then read:
   - Write wr_addr = 0x1A5, wr_data = 0xABC_DEF0_1234, wr_mask = all 1 -> wr_gnt = 1 and sram_wen = 0 that cycle.
   - Next cycle read 0x1A5 -> rd_gnt = 1; following cycle rd_vld = 1 and rd_data = 0xABC_DEF0_1234.
3. Partial mask:
   - wr_mask = 0x000_0000_FFFF -> sram_wen = 0xFFF_FFFF_0000.
   - Read-back shows only the low 16 bits updated.
4. Starvation:
   - wr_req and rd_req held high continuously -> writes granted for 4 cycles, the read is granted on the 5th cycle, then writes resume.
   - Pattern repeats every 5 cycles.
5. inv_req at sweep counter = 300 -> sram_a returns to 0 next cycle; total busy = 512 cycles after the restart.
6. cpurst asserted mid-sweep at counter = 100:
   - Outputs go immediately to reset values (cen = 1).
   - After release, the sweep restarts at address 0.
   - rd_vld stays 0 for any read granted in the cycle before reset.
